// File: rtl/wb2axi_pkg.sv
// Shared types and constants for the Wishbone to AXI4-Lite master bridge.
// FSM state encoding, AXI response codes and the default protection value.
package wb2axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // OKAY and EXOKAY complete with ack; SLVERR and DECERR complete with err.
    function automatic logic resp_is_ok(input logic [1:0] resp);
        return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/wb2axi_watchdog.sv
// Cycle counter that flags an unresponsive AXI slave after LIMIT busy cycles.
// Only instantiated when WB2AXI_WATCHDOG_EN is defined.
module wb2axi_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_to_axi4lite_master.sv
// Pipelined Wishbone slave to AXI4-Lite master bridge, one transaction at a time.
// Optional watchdog for unresponsive slaves is compiled in with WB2AXI_WATCHDOG_EN.
//   state    | meaning
//   ST_IDLE  | waiting for wb_cyc & wb_stb
//   ST_WRITE | AW/W issued, waiting for B
//   ST_READ  | AR issued, waiting for R
//   ST_RESP  | one-cycle ack/err pulse
module wb_to_axi4lite_master
    import wb2axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  wb_cyc,
    input  logic                  wb_stb,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_adr,
    input  logic [3:0]            wb_sel,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_ack,
    output logic                  wb_err,
    output logic                  wb_stall,
    output logic [31:0]           wb_dat_o,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp
);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [31:0]           dat_q;
    logic [3:0]            sel_q;
    logic [1:0]            resp_q;
    logic [31:0]           rdat_q;
    logic                  aw_done, w_done, abandoned;
    logic                  accept, busy, b_hs, r_hs, timeout;

    assign accept = (state == ST_IDLE) && wb_cyc && wb_stb;
    assign busy   = (state == ST_WRITE) || (state == ST_READ);
    assign b_hs   = bvalid && bready;
    assign r_hs   = rvalid && rready;

`ifdef WB2AXI_WATCHDOG_EN
    wb2axi_watchdog #(
        .LIMIT(TIMEOUT)
    ) u_watchdog (
        .clk    (aclk),
        .rst_n  (areset_n),
        .clear  (accept),
        .enable (busy),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A response in the same cycle as the timeout takes priority.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = wb_we ? ST_WRITE : ST_READ;
            ST_WRITE: if (b_hs || timeout) state_next = ST_RESP;
            ST_READ:  if (r_hs || timeout) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        awvalid  = (state == ST_WRITE) && !aw_done;
        wvalid   = (state == ST_WRITE) && !w_done;
        bready   = (state == ST_WRITE);
        arvalid  = (state == ST_READ) && !aw_done;
        rready   = (state == ST_READ);
        wb_stall = (state != ST_IDLE);
        wb_ack   = (state == ST_RESP) && wb_cyc && !abandoned && resp_is_ok(resp_q);
        wb_err   = (state == ST_RESP) && wb_cyc && !abandoned && !resp_is_ok(resp_q);
    end

    // aw_done doubles as the AR handshake flag in READ.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            resp_q    <= RESP_OKAY;
            rdat_q    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            abandoned <= 1'b0;
        end else begin
            if (accept) begin
                adr_q     <= wb_adr;
                dat_q     <= wb_dat_i;
                sel_q     <= wb_sel;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                abandoned <= 1'b0;
            end else begin
                if ((awvalid && awready) || (arvalid && arready)) aw_done <= 1'b1;
                if (wvalid && wready) w_done <= 1'b1;
                if ((state != ST_IDLE) && !wb_cyc) abandoned <= 1'b1;
            end
            if (b_hs) begin
                resp_q <= bresp;
            end else if (r_hs) begin
                resp_q <= rresp;
                rdat_q <= rdata;
            end else if (busy && timeout) begin
                resp_q <= RESP_SLVERR;
            end
        end
    end

    assign awaddr   = adr_q;
    assign araddr   = adr_q;
    assign wdata    = dat_q;
    assign wstrb    = sel_q;
    assign awprot   = PROT_DEFAULT;
    assign arprot   = PROT_DEFAULT;
    assign wb_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_to_axi4lite_master.sv
// Directed testbench for wb_to_axi4lite_master; the watchdog scenario runs
// only when WB2AXI_WATCHDOG_EN is defined (DUT built with TIMEOUT=16).
module tb_wb_to_axi4lite_master;

    logic        aclk;
    logic        areset_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat_i;
    logic        wb_ack, wb_err, wb_stall;
    logic [31:0] wb_dat_o;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int n_checks = 0;
    int n_pass   = 0;

    wb_to_axi4lite_master #(
        .ADDR_WIDTH(32),
        .TIMEOUT   (16)
    ) dut (
        .aclk    (aclk),
        .areset_n(areset_n),
        .wb_cyc  (wb_cyc),
        .wb_stb  (wb_stb),
        .wb_we   (wb_we),
        .wb_adr  (wb_adr),
        .wb_sel  (wb_sel),
        .wb_dat_i(wb_dat_i),
        .wb_ack  (wb_ack),
        .wb_err  (wb_err),
        .wb_stall(wb_stall),
        .wb_dat_o(wb_dat_o),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arprot  (arprot),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc_step();
        @(negedge aclk);
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        #12;
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0)
            $display("FAIL rst_valids: got %b required 00000", {awvalid, wvalid, bready, arvalid, rready});
        else n_pass++;
        n_checks++;
        if ({wb_ack, wb_err, wb_stall} !== 3'b000)
            $display("FAIL rst_wb: got %b required 000", {wb_ack, wb_err, wb_stall});
        else n_pass++;
        n_checks++;
        if ({wb_dat_o, awaddr, araddr, wdata} !== 128'h0)
            $display("FAIL rst_data: got %h %h %h %h required zero", wb_dat_o, awaddr, araddr, wdata);
        else n_pass++;
        n_checks++;
        if ({wstrb, awprot, arprot} !== 10'b0)
            $display("FAIL rst_strb_prot: got %b required 0", {wstrb, awprot, arprot});
        else n_pass++;
        cyc_step();
        areset_n = 1'b1;
    endtask

    task automatic test_write_zero_wait();
        cyc_step();
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h4; wb_dat_i = 32'hDEADBEEF; wb_sel = 4'hF;
        n_checks++;
        if (wb_stall !== 1'b0) $display("FAIL wr0_idle_stall: got %b required 0", wb_stall);
        else n_pass++;
        cyc_step();
        wb_stb = 0;
        n_checks++;
        if ({awvalid, wvalid, wb_stall} !== 3'b111)
            $display("FAIL wr0_valids: got %b required 111", {awvalid, wvalid, wb_stall});
        else n_pass++;
        n_checks++;
        if (awaddr !== 32'h4 || wdata !== 32'hDEADBEEF || wstrb !== 4'hF)
            $display("FAIL wr0_payload: got %h %h %h required 4 deadbeef f", awaddr, wdata, wstrb);
        else n_pass++;
        awready = 1; wready = 1;
        cyc_step();
        awready = 0; wready = 0;
        n_checks++;
        if ({awvalid, wvalid, bready, wb_ack} !== 4'b0010)
            $display("FAIL wr0_after_hs: got %b required 0010", {awvalid, wvalid, bready, wb_ack});
        else n_pass++;
        bvalid = 1; bresp = 2'b00;
        cyc_step();
        bvalid = 0;
        n_checks++;
        if ({wb_ack, wb_err, wb_stall} !== 3'b101)
            $display("FAIL wr0_ack_n3: got %b required 101", {wb_ack, wb_err, wb_stall});
        else n_pass++;
        cyc_step();
        wb_cyc = 0;
        n_checks++;
        if ({wb_ack, wb_stall, bready} !== 3'b000)
            $display("FAIL wr0_back_idle: got %b required 000", {wb_ack, wb_stall, bready});
        else n_pass++;
    endtask

    task automatic test_read_delayed();
        int held;
        held = 0;
        cyc_step();
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h0;
        for (int i = 1; i <= 5; i++) begin
            cyc_step();
            wb_stb = 0;
            if (arvalid === 1'b1 && araddr === 32'h0) held++;
            if (i == 5) arready = 1;
        end
        n_checks++;
        if (held !== 5) $display("FAIL rd_arvalid_held: got %0d cycles required 5", held);
        else n_pass++;
        cyc_step();
        arready = 0;
        n_checks++;
        if ({arvalid, rready} !== 2'b01)
            $display("FAIL rd_after_ar: got %b required 01", {arvalid, rready});
        else n_pass++;
        rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
        cyc_step();
        rvalid = 0; rdata = 32'h0;
        n_checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'h12345678)
            $display("FAIL rd_ack_data: got ack=%b dat=%h required 1 12345678", wb_ack, wb_dat_o);
        else n_pass++;
        cyc_step();
        wb_cyc = 0;
        n_checks++;
        if (wb_ack !== 1'b0 || wb_dat_o !== 32'h12345678)
            $display("FAIL rd_dat_hold: got ack=%b dat=%h required 0 12345678", wb_ack, wb_dat_o);
        else n_pass++;
    endtask

    task automatic test_write_split();
        int acks;
        int bs;
        acks = 0; bs = 0;
        cyc_step();
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h10; wb_dat_i = 32'hCAFEF00D; wb_sel = 4'h3;
        cyc_step();
        wb_stb = 0;
        awready = 1;
        cyc_step();
        awready = 0;
        n_checks++;
        if ({awvalid, wvalid} !== 2'b01)
            $display("FAIL split_aw_first: got %b required 01", {awvalid, wvalid});
        else n_pass++;
        cyc_step();
        cyc_step();
        n_checks++;
        if ({awvalid, wvalid, wstrb} !== 6'b01_0011)
            $display("FAIL split_w_held: got %b required 010011", {awvalid, wvalid, wstrb});
        else n_pass++;
        wready = 1;
        cyc_step();
        wready = 0;
        n_checks++;
        if ({awvalid, wvalid, bready} !== 3'b001)
            $display("FAIL split_w_done: got %b required 001", {awvalid, wvalid, bready});
        else n_pass++;
        bvalid = 1; bresp = 2'b01;
        for (int i = 0; i < 4; i++) begin
            if (bvalid && bready) bs++;
            cyc_step();
            if (wb_ack) acks++;
        end
        bvalid = 0;
        wb_cyc = 0;
        n_checks++;
        if (bs !== 1 || acks !== 1)
            $display("FAIL split_single: got b=%0d acks=%0d required 1 1", bs, acks);
        else n_pass++;
    endtask

    task automatic test_error_resp();
        cyc_step();
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h20; wb_dat_i = 32'h1; wb_sel = 4'h1;
        cyc_step();
        wb_stb = 0; awready = 1; wready = 1;
        cyc_step();
        awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
        cyc_step();
        bvalid = 0; bresp = 2'b00;
        n_checks++;
        if ({wb_ack, wb_err} !== 2'b01)
            $display("FAIL err_slverr: got ack/err %b required 01", {wb_ack, wb_err});
        else n_pass++;
        cyc_step();
        wb_stb = 1; wb_we = 0; wb_adr = 32'h24;
        cyc_step();
        wb_stb = 0; arready = 1;
        cyc_step();
        arready = 0; rvalid = 1; rresp = 2'b11; rdata = 32'h55;
        cyc_step();
        rvalid = 0; rresp = 2'b00;
        n_checks++;
        if ({wb_ack, wb_err} !== 2'b01)
            $display("FAIL err_decerr: got ack/err %b required 01", {wb_ack, wb_err});
        else n_pass++;
        cyc_step();
        wb_cyc = 0;
        n_checks++;
        if ({wb_ack, wb_err, wb_stall} !== 3'b000)
            $display("FAIL err_after: got %b required 000", {wb_ack, wb_err, wb_stall});
        else n_pass++;
    endtask

    task automatic test_cyc_drop();
        cyc_step();
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h30; wb_dat_i = 32'h77; wb_sel = 4'hF;
        cyc_step();
        wb_stb = 0; wb_cyc = 0;
        awready = 1; wready = 1;
        n_checks++;
        if ({awvalid, wvalid} !== 2'b11)
            $display("FAIL drop_still_valid: got %b required 11", {awvalid, wvalid});
        else n_pass++;
        cyc_step();
        awready = 0; wready = 0; bvalid = 1;
        n_checks++;
        if (bready !== 1'b1) $display("FAIL drop_bready: got %b required 1", bready);
        else n_pass++;
        cyc_step();
        bvalid = 0;
        n_checks++;
        if ({wb_ack, wb_err, wb_stall} !== 3'b001)
            $display("FAIL drop_no_pulse: got %b required 001", {wb_ack, wb_err, wb_stall});
        else n_pass++;
        cyc_step();
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h34;
        cyc_step();
        wb_stb = 0; arready = 1;
        cyc_step();
        arready = 0; rvalid = 1; rdata = 32'h0BADF00D;
        cyc_step();
        rvalid = 0;
        n_checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'h0BADF00D)
            $display("FAIL drop_next_req: got ack=%b dat=%h required 1 0badf00d", wb_ack, wb_dat_o);
        else n_pass++;
        cyc_step();
        wb_cyc = 0;
    endtask

    task automatic test_back_to_back();
        cyc_step();
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h40; wb_dat_i = 32'h99; wb_sel = 4'hC;
        cyc_step();
        wb_stb = 0; awready = 1; wready = 1;
        cyc_step();
        awready = 0; wready = 0; bvalid = 1;
        cyc_step();
        bvalid = 0;
        wb_stb = 1; wb_we = 0; wb_adr = 32'h8;
        n_checks++;
        if ({wb_ack, wb_stall} !== 2'b11)
            $display("FAIL b2b_resp: got ack/stall %b required 11", {wb_ack, wb_stall});
        else n_pass++;
        cyc_step();
        n_checks++;
        if ({wb_stall, arvalid} !== 2'b00)
            $display("FAIL b2b_idle: got stall/arvalid %b required 00", {wb_stall, arvalid});
        else n_pass++;
        cyc_step();
        wb_stb = 0;
        n_checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8)
            $display("FAIL b2b_accepted: got arvalid=%b araddr=%h required 1 8", arvalid, araddr);
        else n_pass++;
        arready = 1;
        cyc_step();
        arready = 0; rvalid = 1; rdata = 32'hA5A5A5A5;
        cyc_step();
        rvalid = 0;
        n_checks++;
        if (wb_ack !== 1'b1 || wb_dat_o !== 32'hA5A5A5A5)
            $display("FAIL b2b_read: got ack=%b dat=%h required 1 a5a5a5a5", wb_ack, wb_dat_o);
        else n_pass++;
        cyc_step();
        wb_cyc = 0;
    endtask

    task automatic test_reset_mid_read();
        cyc_step();
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h50;
        cyc_step();
        wb_stb = 0;
        cyc_step();
        n_checks++;
        if (arvalid !== 1'b1) $display("FAIL rstmid_pre: got arvalid=%b required 1", arvalid);
        else n_pass++;
        #2 areset_n = 0;
        #1;
        n_checks++;
        if ({arvalid, rready, wb_stall, wb_err, wb_ack} !== 5'b0)
            $display("FAIL rstmid_drop: got %b required 00000", {arvalid, rready, wb_stall, wb_err, wb_ack});
        else n_pass++;
        cyc_step();
        areset_n = 1; wb_cyc = 0;
        cyc_step();
        cyc_step();
        n_checks++;
        if ({arvalid, wb_stall, wb_err, wb_ack} !== 4'b0)
            $display("FAIL rstmid_after: got %b required 0000", {arvalid, wb_stall, wb_err, wb_ack});
        else n_pass++;
    endtask

`ifdef WB2AXI_WATCHDOG_EN
    task automatic test_watchdog();
        int held;
        int early_err;
        held = 0; early_err = 0;
        cyc_step();
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h60;
        for (int i = 1; i <= 17; i++) begin
            cyc_step();
            wb_stb = 0;
            if (arvalid === 1'b1) held++;
            if (wb_err !== 1'b0) early_err++;
        end
        n_checks++;
        if (held !== 17 || early_err !== 0)
            $display("FAIL wd_wait: got held=%0d early_err=%0d required 17 0", held, early_err);
        else n_pass++;
        cyc_step();
        n_checks++;
        if ({wb_err, wb_ack, arvalid, rready} !== 4'b1000)
            $display("FAIL wd_err: got %b required 1000", {wb_err, wb_ack, arvalid, rready});
        else n_pass++;
        rvalid = 1; rresp = 2'b00;
        cyc_step();
        n_checks++;
        if ({wb_stall, rready, wb_err, wb_ack} !== 4'b0000)
            $display("FAIL wd_idle: got %b required 0000", {wb_stall, rready, wb_err, wb_ack});
        else n_pass++;
        rvalid = 0; wb_cyc = 0;
    endtask
`endif

    initial begin
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_sel = '0; wb_dat_i = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
        test_reset();
        test_write_zero_wait();
        test_read_delayed();
        test_write_split();
        test_error_resp();
        test_cyc_drop();
        test_back_to_back();
        test_reset_mid_read();
`ifdef WB2AXI_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
